// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU input sequencer: FSM states, ALU operation codes
// and flag bit positions within the {N,Z,C,V} flag vector.
package alu_seq_pkg;

   // Low two bits are what the LEDs see; S_SHOW aliases S_EXEC there.
   typedef enum logic [2:0] {
      S_LOAD_A  = 3'd0,
      S_LOAD_B  = 3'd1,
      S_LOAD_OP = 3'd2,
      S_EXEC    = 3'd3,
      S_SHOW    = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic [1:0] state_led(input state_t s);
      logic [2:0] v;
      v = s;
      return v[1:0];
   endfunction

endpackage

// File: rtl/alu_input_sequencer_if.sv
// Bus between the input sequencer (master) and the combinational ALU (slave):
// operands and select out, result and {N,Z,C,V} flags back.
interface alu_input_sequencer_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alu_sel;
   logic [WIDTH-1:0] alu_result;
   logic [3:0]       alu_flags;

   modport master (
      output alu_a,
      output alu_b,
      output alu_sel,
      input  alu_result,
      input  alu_flags
   );

   modport slave (
      input  alu_a,
      input  alu_b,
      input  alu_sel,
      output alu_result,
      output alu_flags
   );
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle press pulse on each accepted 0->1 level change.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);
   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= r_sync2;
               r_press <= r_sync2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign press = r_press;

endmodule

// File: rtl/alu_input_sequencer.sv
// Board-operable front end for the 4-bit ALU: one debounced press per field
// (A, B, op), then capture of the ALU result. Option: ACCUMULATE_EN.
module alu_input_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      sw,
   input  logic [1:0]            sw_op,
   input  logic                  btn_next,
   alu_input_sequencer_if.master alu_bus,
   output logic [WIDTH-1:0]      result_q,
   output logic [3:0]            flags_q,
   output logic [1:0]            state_o,
   output logic                  done
);
   logic             w_press;
   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   alu_op_t          r_sel;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic             r_done;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_next),
      .press  (w_press)
   );

   // Field-loading FSM; S_EXEC ignores the button so a press there is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_LOAD_A;
         r_a      <= '0;
         r_b      <= '0;
         r_sel    <= ALU_ADD;
         r_result <= '0;
         r_flags  <= 4'b0000;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD_A: begin
               if (w_press) begin
                  r_a     <= sw;
                  r_state <= S_LOAD_B;
               end
            end
            S_LOAD_B: begin
               if (w_press) begin
                  r_b     <= sw;
                  r_state <= S_LOAD_OP;
               end
            end
            S_LOAD_OP: begin
               if (w_press) begin
                  r_sel   <= alu_op_t'(sw_op);
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_result <= alu_bus.alu_result;
               r_flags  <= alu_bus.alu_flags;
               r_done   <= 1'b1;
               r_state  <= S_SHOW;
            end
            S_SHOW: begin
               if (w_press) begin
                  r_done <= 1'b0;
`ifdef ACCUMULATE_EN
                  r_a     <= r_result;
                  r_state <= S_LOAD_B;
`else
                  r_state <= S_LOAD_A;
`endif
               end
            end
            default: begin
               r_state <= S_LOAD_A;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign alu_bus.alu_a   = r_a;
   assign alu_bus.alu_b   = r_b;
   assign alu_bus.alu_sel = r_sel;
   assign result_q        = r_result;
   assign flags_q         = r_flags;
   assign done            = r_done;
   assign state_o         = state_led(r_state);

endmodule
